// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control FSM with fetch/decode/exec/mem/writeback sequencing.
// It also keeps retired-instruction and free-running cycle counters.
module cpu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        isR,
  input  logic        isI,
  input  logic        isJ,
  input  logic        isLd,
  input  logic        isSt,
  input  logic        isCond,
  input  logic        br_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  pc_src,
  output logic        wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [31:0] cycles
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100
  } state_e;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  logic [2:0]  state_q, state_d;
  logic        fetch_pending_q, fetch_pending_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] cycles_q, cycles_d;
  logic        retire;

  logic        imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c;
  logic        rf_we_c, wb_sel_c, illegal_c;
  logic [1:0]  pc_src_c;

  always_comb begin
    state_d         = state_q;
    fetch_pending_d = fetch_pending_q;
    retire          = 1'b0;
    imem_req_c      = 1'b0;
    dmem_req_c      = 1'b0;
    dmem_we_c       = 1'b0;
    ir_we_c         = 1'b0;
    pc_we_c         = 1'b0;
    rf_we_c         = 1'b0;
    wb_sel_c        = 1'b0;
    illegal_c       = 1'b0;
    pc_src_c        = PC_SEQ;

    case (state_q)
      S_FETCH: begin
        // An issued request stays up until the memory answers, even if run drops.
        imem_req_c = run | fetch_pending_q;
        if (imem_req_c) begin
          if (imem_ready) begin
            ir_we_c         = 1'b1;
            pc_we_c         = 1'b1;
            pc_src_c        = PC_SEQ;
            fetch_pending_d = 1'b0;
            state_d         = S_DECODE;
          end else begin
            fetch_pending_d = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (isJ) begin
          pc_we_c  = 1'b1;
          pc_src_c = PC_JMP;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (isLd | isSt) begin
          state_d = S_MEM;
        end else if (isCond) begin
          pc_we_c  = br_taken;
          pc_src_c = br_taken ? PC_BR : PC_SEQ;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (isR | isI) begin
          state_d = S_WB;
        end else begin
          illegal_c = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = isSt;
        if (dmem_ready) begin
          if (isLd) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we_c  = 1'b1;
        wb_sel_c = isLd;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    retired_d = retired_q + {31'd0, retire};
    cycles_d  = cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_FETCH;
      fetch_pending_q <= 1'b0;
      retired_q       <= 32'd0;
      cycles_q        <= 32'd0;
    end else begin
      state_q         <= state_d;
      fetch_pending_q <= fetch_pending_d;
      retired_q       <= retired_d;
      cycles_q        <= cycles_d;
    end
  end

  // Outputs are masked by rst_n so an asserted run cannot raise imem_req in reset.
  assign imem_req = rst_n & imem_req_c;
  assign dmem_req = rst_n & dmem_req_c;
  assign dmem_we  = rst_n & dmem_we_c;
  assign ir_we    = rst_n & ir_we_c;
  assign pc_we    = rst_n & pc_we_c;
  assign rf_we    = rst_n & rf_we_c;
  assign wb_sel   = rst_n & wb_sel_c;
  assign illegal  = rst_n & illegal_c;
  assign pc_src   = rst_n ? pc_src_c : PC_SEQ;
  assign state    = state_q;
  assign retired  = retired_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: instruction-level expected traces built from
// class/latency rules, compared against the DUT every cycle, plus literal pins.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, run;
  logic        isR, isI, isJ, isLd, isSt, isCond;
  logic        br_taken, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, wb_sel, illegal;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic [31:0] retired, cycles;

  cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .isR(isR), .isI(isI), .isJ(isJ), .isLd(isLd), .isSt(isSt), .isCond(isCond),
    .br_taken(br_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .pc_src(pc_src), .wb_sel(wb_sel),
    .state(state), .illegal(illegal), .retired(retired), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [12:0] exp_vec;
  logic [31:0] m_retired, m_cycles;
  bit          chk_en = 1'b0;
  bit          log_en = 1'b0;
  logic [2:0]  st_log[$];
  logic [12:0] act_vec;

  assign act_vec = {state, imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we, rf_we, wb_sel, illegal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] mk(input logic [2:0] st, input logic ireq, input logic irwe,
                                     input logic pcwe, input logic [1:0] psrc, input logic dreq,
                                     input logic dwe, input logic rfwe, input logic wsel,
                                     input logic ill);
    return {st, ireq, irwe, pcwe, psrc, dreq, dwe, rfwe, wsel, ill};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs", {19'd0, act_vec}, {19'd0, exp_vec});
      chk("retired", retired, m_retired);
      chk("cycles", cycles, m_cycles);
      if (log_en) st_log.push_back(state);
    end
  end

  // One clock with the given expectation; retire takes effect on this edge.
  task automatic step(input logic [12:0] e, input bit ret);
    exp_vec = e;
    @(posedge clk);
    if (ret) m_retired = m_retired + 32'd1;
    m_cycles = m_cycles + 32'd1;
    #1;
  endtask

  task automatic noise();
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    br_taken   = 1'($urandom);
  endtask

  task automatic set_flags(input logic [5:0] f);
    {isJ, isLd, isSt, isCond, isR, isI} = f;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    run   = 1'b1;
    exp_vec   = 13'd0;
    m_cycles  = 32'd0;
    m_retired = 32'd0;
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b0;
  endtask

  task automatic idle(input int nc);
    for (int k = 0; k < nc; k++) begin
      noise();
      run = 1'b0;
      step(13'd0, 1'b0);
    end
  endtask

  // Flag vector order: {isJ, isLd, isSt, isCond, isR, isI}
  task automatic run_instr(input logic [5:0] fl, input logic br, input int iw, input int dw,
                           input int abort, input bit drop, output int n);
    logic j, ld, st, cd, al;
    {j, ld, st, cd} = fl[5:2];
    al = fl[1] | fl[0];
    n = 0;
    for (int k = 0; k < iw; k++) begin
      noise();
      imem_ready = 1'b0;
      set_flags(6'($urandom));
      run = (k == 0) ? 1'b1 : (drop ? 1'b0 : 1'($urandom));
      step(mk(3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
      n++;
    end
    noise();
    imem_ready = 1'b1;
    set_flags(6'($urandom));
    run = (iw == 0) ? 1'b1 : (drop ? 1'b0 : 1'($urandom));
    step(mk(3'd0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    n++;

    noise();
    run = drop ? 1'b0 : 1'($urandom);
    set_flags(fl);
    if (j) begin
      step(mk(3'd1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
      n++;
      return;
    end
    step(mk(3'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    n++;

    noise();
    br_taken = br;
    if (!(ld | st)) begin
      if (cd) begin
        step(mk(3'd2, 1'b0, 1'b0, br, br ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        n++;
        return;
      end
      if (!al) begin
        step(mk(3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
        n++;
        return;
      end
      step(13'(mk(3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)), 1'b0);
      n++;
    end else begin
      step(mk(3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
      n++;
      for (int k = 0; k <= dw; k++) begin
        if (k == abort) begin
          chk("mem_req_before_reset", {31'd0, dmem_req}, 32'd1);
          do_reset(2);
          n = -1;
          return;
        end
        noise();
        dmem_ready = (k == dw);
        step(mk(3'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, st, 1'b0, 1'b0, 1'b0), (k == dw) && !ld);
        n++;
      end
      if (!ld) return;
    end
    noise();
    step(mk(3'd4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, ld, 1'b0), 1'b1);
    n++;
  endtask

  function automatic logic [5:0] pick();
    logic [5:0] f;
    f = 6'($urandom);
    case ($urandom_range(0, 5))
      0: f[5] = 1'b1;
      1: begin f[5] = 1'b0; f[4] = 1'b1; f[3] = 1'b0; end
      2: begin f[5] = 1'b0; f[4] = 1'b0; f[3] = 1'b1; end
      3: begin f[5:2] = 4'b0001; end
      4: begin f[5:2] = 4'b0000; f[1:0] = 2'($urandom_range(1, 3)); end
      default: f = 6'd0;
    endcase
    return f;
  endfunction

  initial begin
    int n;
    rst_n = 1'b1; run = 1'b0;
    set_flags(6'd0);
    br_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    exp_vec = 13'd0; m_retired = 32'd0; m_cycles = 32'd0;
    #2;
    chk_en = 1'b1;
    do_reset(3);

    // ALU right after release: states 0,1,2,4 and one retire after 4 cycles
    log_en = 1'b1;
    run_instr(6'b000010, 1'b0, 0, 0, -1, 1'b0, n);
    log_en = 1'b0;
    chk("alu_latency", n, 4);
    chk("alu_states", {20'd0, st_log[0], st_log[1], st_log[2], st_log[3]}, 32'o0124);
    chk("alu_retired", retired, 32'd1);
    chk("alu_cycles", cycles, 32'd4);

    // Load with three dmem wait cycles
    run_instr(6'b010000, 1'b0, 0, 3, -1, 1'b0, n);
    chk("load_latency", n, 8);
    chk("load_retired", retired, 32'd2);

    // Taken then not-taken branch
    run_instr(6'b000100, 1'b1, 0, 0, -1, 1'b0, n);
    chk("br_taken_latency", n, 3);
    run_instr(6'b000100, 1'b0, 0, 0, -1, 1'b0, n);
    chk("br_retired", retired, 32'd4);

    // Jump with isCond also set never reaches EXEC
    run_instr(6'b100100, 1'b1, 0, 0, -1, 1'b0, n);
    chk("jump_latency", n, 2);

    // Store with zero waits, then illegal
    run_instr(6'b001000, 1'b0, 0, 0, -1, 1'b0, n);
    chk("store_latency", n, 4);
    run_instr(6'b000000, 1'b0, 0, 0, -1, 1'b0, n);
    chk("illegal_latency", n, 3);
    chk("seq_retired", retired, 32'd7);

    // run dropped while the fetch is waiting; no further fetch while run=0
    run_instr(6'b000001, 1'b0, 2, 0, -1, 1'b1, n);
    chk("drop_latency", n, 6);
    idle(4);

    // Reset in MEM with a store outstanding, then no fetch until run rises
    run_instr(6'b001000, 1'b0, 0, 5, 2, 1'b0, n);
    chk("abort_flag", n, -1);
    idle(3);
    chk("abort_retired", retired, 32'd0);
    chk("abort_cycles", cycles, 32'd3);

    // Randomized instruction stream
    for (int t = 0; t < 250; t++) begin
      int ab;
      int dw;
      dw = $urandom_range(0, 3);
      ab = ($urandom_range(0, 24) == 0) ? $urandom_range(0, dw) : -1;
      run_instr(pick(), 1'($urandom), $urandom_range(0, 3), dw, ab, 1'($urandom), n);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL provide port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL provide port run, input, 1, permits the start of a new instruction fetch.
REQ-004 SHALL provide ports isR, isI, isJ, isLd, isSt, isCond, input, 1 each, instruction-class flags from the instruction decoder, driven from the instruction register and stable from DECODE until the instruction retires.
REQ-005 SHALL provide port br_taken, input, 1, ALU branch-condition result, valid in EXEC.
REQ-006 SHALL provide ports imem_ready and dmem_ready, input, 1 each, memory completion strobes.
REQ-007 SHALL provide ports imem_req, dmem_req and dmem_we, output, 1 each, memory request and store qualifier.
REQ-008 SHALL provide ports ir_we, pc_we and rf_we, output, 1 each, instruction-register, PC and register-file write enables.
REQ-009 SHALL provide ports pc_src (output, 2; 00 = PC+4, 01 = branch target, 10 = jump target) and wb_sel (output, 1; 0 = ALU, 1 = memory data).
REQ-010 SHALL provide ports state (output, 3), illegal (output, 1), retired (output, 32) and cycles (output, 32).

Function
REQ-011 SHALL implement states FETCH=000, DECODE=001, EXEC=010, MEM=011 and WB=100; encodings 101-111 SHALL return to FETCH on the next cycle.
REQ-012 In FETCH, imem_req SHALL be asserted when run=1 or fetch_pending=1; fetch_pending SHALL set on issue and clear on imem_ready, so a request, once raised, holds until imem_ready even if run drops.
REQ-013 In FETCH with imem_req=1 and imem_ready=1, the block SHALL assert ir_we=1, pc_we=1 and pc_src=00 for that cycle and go to DECODE; with imem_ready=0 it SHALL stay in FETCH with no other outputs asserted.
REQ-014 In DECODE, if isJ=1 the block SHALL assert pc_we=1 with pc_src=10, retire, and go to FETCH; otherwise it SHALL go to EXEC.
REQ-015 In EXEC, classification priority SHALL be: (isLd|isSt) -> MEM; isCond -> branch; (isR|isI) -> WB; else illegal.
REQ-016 In EXEC on a branch, the block SHALL assert pc_we=1 with pc_src=01 if br_taken=1, then retire and go to FETCH.
REQ-017 An illegal class in EXEC SHALL pulse illegal=1 for one cycle, retire with no writes, and go to FETCH.
REQ-018 In MEM, dmem_req=1 and dmem_we=isSt SHALL be held until dmem_ready; on dmem_ready a load SHALL go to WB, and a store SHALL retire and go to FETCH.
REQ-019 In WB, rf_we=1 with wb_sel=isLd SHALL be asserted for exactly one cycle, then the block SHALL retire and go to FETCH.
REQ-020 Control outputs SHALL be combinational from state and inputs; any output not stated above for a given state SHALL be 0.
REQ-021 Retire SHALL increment retired by 1, modulo 2^32, on the retiring edge.
REQ-022 cycles SHALL increment every clock out of reset, wrapping from FFFFFFFF to 0.
REQ-023 Latencies with zero-wait memory SHALL be: jump 2 cycles, branch/illegal 3, ALU 4, store 4, load 5.

Reset
REQ-024 While rst_n=0, the block SHALL hold state=FETCH, fetch_pending=0, retired=0 and cycles=0, and force every 1-bit output to 0 regardless of run.
REQ-025 Reset asserted mid-instruction, including with a memory request outstanding, SHALL abort the instruction without retiring it; the first fetch after release SHALL occur only when run=1.

Verification
REQ-026 Reset release with run=1, imem_ready=1 and an ALU instruction (isR=1) -> states 0,1,2,4,0; rf_we=1 with wb_sel=0 on cycle 4; retired=1 after 4 cycles.
REQ-027 Load with dmem_ready low for 3 MEM cycles -> dmem_req=1 and dmem_we=0 for 4 cycles, then WB with wb_sel=1; total 8 cycles.
REQ-028 Branch with br_taken=1, then a branch with br_taken=0 -> pc_we=1 with pc_src=01 in EXEC only for the first; both retire; retired=2.
REQ-029 Jump (isJ=1, isCond=1) -> pc_we=1 with pc_src=10 in DECODE; EXEC is never entered.
REQ-030 run dropped to 0 after imem_req rises, with imem_ready delayed 2 cycles -> imem_req stays 1 until ready; no fetch follows while run=0.
REQ-031 rst_n pulsed low in MEM with a store pending -> dmem_req=0 immediately, state=000, retired=0, cycles=0.
